// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load-store unit.
//   lsu_size_t  - access size, encoded as funct3[1:0]
//   lsu_state_t - transaction FSM states
//   BE_WIDTH    - number of byte lanes on the data-memory bus
package lsu_pkg;
   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } lsu_size_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID,
      RESP
   } lsu_state_t;

   localparam int BE_WIDTH = 4;
endpackage

// File: rtl/lsu_if.sv
// lsu_if / lsu_mem_if: bus bundles around the load-store unit.
//   lsu_if     - execute request (req_*) and writeback response (rsp_*);
//                master = execute stage, slave = lsu
//   lsu_mem_if - request/grant/rvalid data-memory bus (mem_*);
//                master = lsu, slave = memory
interface lsu_if
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   lsu_size_t             req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_misaligned;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
   );
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
   );
endinterface

interface lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_gnt;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BE_WIDTH-1:0]   mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load-store unit.
//   size, is_unsigned, addr_lo - access size, zero-extend flag, address[1:0]
//   wdata -> wdata_lane, be    - store data replicated across lanes, byte enables
//   rdata -> rdata_ext         - load word shifted down and sign/zero extended
//   misaligned                 - HALF on odd address or WORD not on a word boundary
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  lsu_size_t             size,
   input  logic                  is_unsigned,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [BE_WIDTH-1:0]   be,
   output logic [DATA_WIDTH-1:0] wdata_lane,
   output logic [DATA_WIDTH-1:0] rdata_ext,
   output logic                  misaligned
);
   logic [DATA_WIDTH-1:0] word;
   logic                  sext_b;
   logic                  sext_h;

   assign word   = rdata >> {addr_lo, 3'b000};
   assign sext_b = ~is_unsigned & word[7];
   assign sext_h = ~is_unsigned & word[15];

   // The reserved size encoding 2'b11 is handled as WORD throughout.
   always_comb begin
      misaligned = size == HALF ? addr_lo[0] : size == BYTE ? 1'b0 : addr_lo != 2'b00;
      be         = size == BYTE ? 4'b0001 << addr_lo : size == HALF ? 4'b0011 << addr_lo : 4'b1111;
      wdata_lane = size == BYTE ? {4{wdata[7:0]}} : size == HALF ? {2{wdata[15:0]}} : wdata;
      rdata_ext  = size == BYTE ? {{(DATA_WIDTH-8){sext_b}}, word[7:0]} :
                   size == HALF ? {{(DATA_WIDTH-16){sext_h}}, word[15:0]} : word;
   end
endmodule

// File: rtl/lsu.sv
// lsu: RV32 load-store unit, one data-memory transaction at a time.
//   clk, rst_n - clock, asynchronous active-low reset
//   req_bus    - execute request in, writeback response out (lsu_if.slave)
//   mem_bus    - request/grant/rvalid data-memory bus (lsu_mem_if.master)
module lsu
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic        clk,
   input logic        rst_n,
   lsu_if.slave       req_bus,
   lsu_mem_if.master  mem_bus
);
   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("lsu: DATA_WIDTH must be 32");
   end

   lsu_state_t            state_q, state_d;
   logic                  we_q, we_d;
   lsu_size_t             size_q, size_d;
   logic                  uns_q, uns_d;
   logic [1:0]            lo_q, lo_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  mis_q, mis_d;

   logic                  idle;
   lsu_size_t             a_size;
   logic                  a_uns;
   logic [1:0]            a_lo;
   logic [BE_WIDTH-1:0]   a_be;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic [DATA_WIDTH-1:0] a_rdata;
   logic                  a_mis;

   assign idle = state_q == IDLE;

   // One aligner serves both directions: in IDLE it steers the incoming
   // store, afterwards it extracts load data using the captured attributes.
   assign a_size = idle ? req_bus.req_size : size_q;
   assign a_uns  = idle ? req_bus.req_unsigned : uns_q;
   assign a_lo   = idle ? req_bus.req_addr[1:0] : lo_q;

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .size        (a_size),
      .is_unsigned (a_uns),
      .addr_lo     (a_lo),
      .wdata       (req_bus.req_wdata),
      .rdata       (mem_bus.mem_rdata),
      .be          (a_be),
      .wdata_lane  (a_wdata),
      .rdata_ext   (a_rdata),
      .misaligned  (a_mis)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      lo_d    = lo_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      case (state_q)
         IDLE: if (req_bus.req_valid) begin
            we_d    = req_bus.req_we;
            size_d  = req_bus.req_size;
            uns_d   = req_bus.req_unsigned;
            lo_d    = req_bus.req_addr[1:0];
            addr_d  = {req_bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            be_d    = a_be;
            wdata_d = a_wdata;
            mis_d   = a_mis;
            rdata_d = a_mis ? '0 : rdata_q;
            state_d = a_mis ? RESP : WAIT_GNT;
         end
         WAIT_GNT: if (mem_bus.mem_gnt) begin
            rdata_d = we_q ? '0 : rdata_q;
            state_d = we_q ? RESP : WAIT_RVALID;
         end
         WAIT_RVALID: if (mem_bus.mem_rvalid) begin
            rdata_d = a_rdata;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= BYTE;
         uns_q   <= 1'b0;
         lo_q    <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         lo_q    <= lo_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   // mem_req decodes straight from the state register so reset drops it at once.
   assign req_bus.req_ready      = idle;
   assign req_bus.rsp_valid      = state_q == RESP;
   assign req_bus.rsp_rdata      = rdata_q;
   assign req_bus.rsp_misaligned = mis_q;
   assign mem_bus.mem_req        = state_q == WAIT_GNT;
   assign mem_bus.mem_we         = we_q;
   assign mem_bus.mem_addr       = addr_q;
   assign mem_bus.mem_be         = be_q;
   assign mem_bus.mem_wdata      = wdata_q;
endmodule

// File: doc/lsu.md
# lsu

Load-store unit for the RV32 execute/memory boundary, directly downstream of the ALU. It takes the ALU result as the effective address, along with rs2 data and the access size from decode. It runs one data-memory transaction at a time over a request/grant/rvalid bus and returns the aligned, sign- or zero-extended load data, or a store completion, to writeback. Misaligned accesses never reach memory and are reported as a fault.

## Interface
- `DATA_WIDTH`, 32: data path width. Only 32 is legal; any other value is an elaboration error.
- `ADDR_WIDTH`, 32: address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute presents a memory op.
- `req_ready` out 1: unit can accept; equals (state == IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in `lsu_size_t`: BYTE/HALF/WORD.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU).
- `req_addr` in ADDR_WIDTH: effective address (ALU `opr_result`).
- `req_wdata` in DATA_WIDTH: store data (rs2).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: extended load data; 0 for stores and faults; held until the next response.
- `rsp_misaligned` out 1: fault flag, valid with `rsp_valid`.
- `mem_req` out 1: memory request.
- `mem_gnt` in 1: memory accepted the request this cycle.
- `mem_we` out 1: write enable.
- `mem_addr` out ADDR_WIDTH: word address, with `[1:0]` = 0.
- `mem_be` out 4: byte enables.
- `mem_wdata` out DATA_WIDTH: lane-replicated store data.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in DATA_WIDTH: read word.

## Operation
- **FSM states:** IDLE, WAIT_GNT, WAIT_RVALID, RESP.
- **IDLE:**
  - A request is accepted on `req_valid && req_ready`.
  - Accepting captures `req_we`, `req_size`, `req_unsigned` and `req_addr[1:0]`, and registers `mem_addr`, `mem_be` and `mem_wdata`.
  - A misaligned request goes to RESP with the fault flag set. Misaligned means HALF with `addr[0]` = 1, or WORD with `addr[1:0]` ≠ 0.
  - An aligned request goes to WAIT_GNT.
- **WAIT_GNT:**
  - `mem_req` = 1.
  - `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` stay stable until `mem_gnt`.
  - On `mem_gnt`: a store goes to RESP, a load goes to WAIT_RVALID.
- **WAIT_RVALID:**
  - `mem_req` = 0.
  - On `mem_rvalid`, the data is extracted and extended into `rsp_rdata`, then the FSM goes to RESP.
- **RESP:** `rsp_valid` = 1 for exactly one cycle, then the FSM returns to IDLE.
- **Store lanes:**
  - BYTE: wdata = {4{`wdata[7:0]`}}, be = 4'b0001 << `addr[1:0]`.
  - HALF: wdata = {2{`wdata[15:0]`}}, be = 4'b0011 << `addr[1:0]`.
  - WORD: wdata passed through, be = 4'b1111.
- **Load data:** word = `mem_rdata` >> (8·`addr[1:0]`). BYTE/HALF take the low 8/16 bits and sign-extend unless `req_unsigned` is set; WORD passes through.
- **Loads:** `mem_we` = 0 and `mem_be` is set per size. Memory ignores `mem_be` on reads.
- **Ignored inputs:** `mem_gnt` outside WAIT_GNT and `mem_rvalid` outside WAIT_RVALID are ignored. Only one transaction is outstanding at a time.

## Timing
- **Reset values:** state = IDLE; `rsp_valid`, `rsp_misaligned`, `rsp_rdata`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` all = 0; `req_ready` = 1.
- **Reset mid-transaction:** the transaction is aborted and `mem_req` drops asynchronously. No response is produced, and a late `mem_rvalid` is then ignored.
- **Cycle numbering:** acceptance is cycle 0.
  - `mem_req` rises in cycle 1.
  - A store with `mem_gnt` in cycle 1 gives `rsp_valid` in cycle 2.
  - A load gets `mem_rvalid` no earlier than cycle 2, giving `rsp_valid` in cycle 3.
  - Each cycle without `mem_gnt` or `mem_rvalid` adds one cycle of latency.
- **Misaligned:** `rsp_valid` with `rsp_misaligned` = 1 in cycle 1; `mem_req` is never asserted.
- **Back-to-back:** `req_ready` is low from cycle 1 until the cycle after `rsp_valid`. The minimum issue interval is 3 cycles for stores and 4 for loads.

## Structure
- **Package `lsu_pkg`:**
  - `lsu_size_t`: 2-bit; BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, matching funct3[1:0].
  - `lsu_state_t`: IDLE, WAIT_GNT, WAIT_RVALID, RESP.
  - Constant `BE_WIDTH` = 4.
- **Sub-module `lsu_align`:** combinational. It computes store lane/`be`, load extract/extend and the misaligned flag from size, unsigned and `addr[1:0]`. The FSM and registers stay in `lsu`.

## Test plan
- Word store to addr 0x1000_0004, wdata 0xDEADBEEF, `mem_gnt` in cycle 1:
  - Memory side: `mem_addr` 0x1000_0004, `mem_be` 4'b1111, `mem_wdata` 0xDEADBEEF.
  - Response: `rsp_valid` in cycle 2, `rsp_rdata` 0.
- Byte load (signed) from addr 0x…03 with `mem_rdata` 0x80FF_0011: `rsp_rdata` 0xFFFF_FF80. The same access with `req_unsigned` = 1 gives 0x0000_0080.
- Half store, wdata 0x0000_ABCD at addr 0x…02: `mem_be` 4'b1100, `mem_wdata` 0xABCD_ABCD.
- Word load at addr 0x…01: `rsp_valid` with `rsp_misaligned` = 1 in cycle 1, `mem_req` stays 0.
- `mem_gnt` withheld 3 cycles and `mem_rvalid` 2 cycles after grant:
  - `mem_addr`/`mem_be` hold stable throughout.
  - `req_ready` stays 0.
  - Exactly one `rsp_valid` pulse.
- `rst_n` asserted in WAIT_RVALID, then `mem_rvalid` pulsed after release: no `rsp_valid`, all outputs at reset values, `req_ready` = 1.
